// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule sequencer sharing one external 4-byte S-box.
// Optional round-key store is built when AES_KEY_SCHED_CACHE_EN is defined.
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int SBOX_LAT   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         start_ready,
  input  logic         abort,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
`ifdef AES_KEY_SCHED_CACHE_EN
  ,
  input  logic [3:0]   cache_rd_idx,
  output logic [127:0] cache_rd_data,
  output logic         cache_valid
`endif
);

  typedef enum logic [1:0] {IDLE, EMIT, CALC} state_t;

  state_t       state, state_nxt;
  logic [127:0] key_q;
  logic [7:0]   rcon;
  logic [3:0]   round;
  logic [1:0]   wait_cnt;
  logic         start_acc, handshake, last_key;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_q;
  assign start_acc = (state == IDLE) && start;
  assign handshake = (state == EMIT) && rk_ready;
  assign last_key  = (round == 4'(NUM_ROUNDS));

  // Next round key from the S-box result of RotWord(w3).
  assign t  = sbox_out ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_data = key_q;
  assign rk_idx  = round;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b1;
    rk_valid    = 1'b0;
    sbox_in     = 32'h0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start) state_nxt = EMIT;
      end
      EMIT: begin
        rk_valid = 1'b1;
        if (abort)         state_nxt = IDLE;
        else if (rk_ready) state_nxt = last_key ? IDLE : CALC;
      end
      CALC: begin
        sbox_in = {w3[23:0], w3[31:24]};
        if (abort)               state_nxt = IDLE;
        else if (wait_cnt == 2'd0) state_nxt = EMIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Abort always wins over a coincident handshake or S-box sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      rcon     <= 8'h01;
      round    <= 4'd0;
      wait_cnt <= 2'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_acc) begin
        key_q    <= key_in;
        round    <= 4'd0;
        rcon     <= 8'h01;
        wait_cnt <= 2'd0;
      end else if (handshake && !abort) begin
        if (last_key) done <= 1'b1;
        else          wait_cnt <= 2'(SBOX_LAT);
      end else if (state == CALC && !abort) begin
        if (wait_cnt != 2'd0) begin
          wait_cnt <= wait_cnt - 2'd1;
        end else begin
          key_q <= {n0, n1, n2, n3};
          round <= round + 4'd1;
          rcon  <= rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
        end
      end
    end
  end

`ifdef AES_KEY_SCHED_CACHE_EN
  logic [127:0] store [0:NUM_ROUNDS];

  always_ff @(posedge clk) begin
    if (handshake) store[rk_idx] <= rk_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_rd_data <= '0;
      cache_valid   <= 1'b0;
    end else begin
      cache_rd_data <= (cache_rd_idx <= 4'(NUM_ROUNDS)) ? store[cache_rd_idx] : '0;
      if (start_acc || (abort && state != IDLE))
        cache_valid <= 1'b0;
      else if (handshake && last_key)
        cache_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: three instances (SBOX_LAT 0, 1, 3)
// fed by ideal S-box models; round keys checked against the FIPS-197 example.
module tb_aes_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic [2047:0] sbox_bits = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    sb = sbox_bits[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  logic [127:0] key_drv;
  logic         tie0 = 1'b0;
  logic         tie1 = 1'b1;

  logic start0, start1, start3, abort1, ready1;
  logic start_ready0, start_ready1, start_ready3;
  logic [31:0] sbox_in0, sbox_in1, sbox_in3;
  logic [31:0] sbox_out0, sbox_out1, sbox_out3, p3a, p3b;
  logic rk_valid0, rk_valid1, rk_valid3;
  logic [127:0] rk_data0, rk_data1, rk_data3;
  logic [3:0] rk_idx0, rk_idx1, rk_idx3;
  logic busy0, busy1, busy3, done0, done1, done3;
`ifdef AES_KEY_SCHED_CACHE_EN
  logic [3:0] cache_idx0, cache_idx1, cache_idx3;
  logic [127:0] cache_data0, cache_data1, cache_data3;
  logic cache_valid0, cache_valid1, cache_valid3;
  assign cache_idx0 = 4'd0;
  assign cache_idx3 = 4'd0;
`endif

  // Ideal S-box models with latency matching each instance.
  assign sbox_out0 = sub_word(sbox_in0);
  always @(posedge clk) sbox_out1 <= sub_word(sbox_in1);
  always @(posedge clk) begin
    p3a       <= sub_word(sbox_in3);
    p3b       <= p3a;
    sbox_out3 <= p3b;
  end

  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .SBOX_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .key_in(key_drv), .start_ready(start_ready0),
    .abort(tie0), .sbox_in(sbox_in0), .sbox_out(sbox_out0), .rk_valid(rk_valid0),
    .rk_ready(tie1), .rk_data(rk_data0), .rk_idx(rk_idx0), .busy(busy0), .done(done0)
`ifdef AES_KEY_SCHED_CACHE_EN
    , .cache_rd_idx(cache_idx0), .cache_rd_data(cache_data0), .cache_valid(cache_valid0)
`endif
  );

  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .SBOX_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key_in(key_drv), .start_ready(start_ready1),
    .abort(abort1), .sbox_in(sbox_in1), .sbox_out(sbox_out1), .rk_valid(rk_valid1),
    .rk_ready(ready1), .rk_data(rk_data1), .rk_idx(rk_idx1), .busy(busy1), .done(done1)
`ifdef AES_KEY_SCHED_CACHE_EN
    , .cache_rd_idx(cache_idx1), .cache_rd_data(cache_data1), .cache_valid(cache_valid1)
`endif
  );

  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .SBOX_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .key_in(key_drv), .start_ready(start_ready3),
    .abort(tie0), .sbox_in(sbox_in3), .sbox_out(sbox_out3), .rk_valid(rk_valid3),
    .rk_ready(tie1), .rk_data(rk_data3), .rk_idx(rk_idx3), .busy(busy3), .done(done3)
`ifdef AES_KEY_SCHED_CACHE_EN
    , .cache_rd_idx(cache_idx3), .cache_rd_data(cache_data3), .cache_valid(cache_valid3)
`endif
  );

  logic [131:0] q0[$], q1[$], q3[$];
  logic         space_on = 1'b1;
  int done_cnt0 = 0, done_cnt1 = 0, done_cnt3 = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic noteFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic scoreKey(input string tag, input logic [3:0] idx, input logic [127:0] data,
                          input logic [131:0] e, input int gap, input int spacing);
    checkOutput({tag, " rk_idx"}, 128'(idx), 128'(e[131:128]));
    checkOutput({tag, " rk_data"}, data, e[127:0]);
    if (space_on && e[131:128] != 4'd0)
      checkOutput({tag, " spacing"}, 128'(gap), 128'(spacing));
  endtask

  // Monitors: pop one expected key per handshake, sampled on the falling edge.
  int last0 = 0, last1 = 0, last3 = 0;
  always @(negedge clk) begin
    if (rk_valid0) begin
      if (q0.size() == 0) noteFail("lat0 unexpected key");
      else scoreKey("lat0", rk_idx0, rk_data0, q0.pop_front(), cyc - last0, 2);
      last0 = cyc;
    end
    if (rk_valid1 && ready1) begin
      if (q1.size() == 0) noteFail("lat1 unexpected key");
      else scoreKey("lat1", rk_idx1, rk_data1, q1.pop_front(), cyc - last1, 3);
      last1 = cyc;
    end
    if (rk_valid3) begin
      if (q3.size() == 0) noteFail("lat3 unexpected key");
      else scoreKey("lat3", rk_idx3, rk_data3, q3.pop_front(), cyc - last3, 5);
      last3 = cyc;
    end
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (done3) done_cnt3++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a start on one lane and queue the full expected key stream.
  task automatic applyStimulus(input int lane);
    key_drv = KEY;
    for (int i = 0; i <= 10; i++) begin
      case (lane)
        0: q0.push_back({4'(i), RK[i]});
        1: q1.push_back({4'(i), RK[i]});
        default: q3.push_back({4'(i), RK[i]});
      endcase
    end
    case (lane)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start3 = 1'b1;
    endcase
    tick(1);
    start0 = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    case (lane)
      0: checkOutput("lat0 rk0 latency", 128'(rk_valid0), 128'd1);
      1: checkOutput("lat1 rk0 latency", 128'(rk_valid1), 128'd1);
      default: checkOutput("lat3 rk0 latency", 128'(rk_valid3), 128'd1);
    endcase
  endtask

  task automatic waitIdle(input int lane, input string tag);
    int n = 0;
    while (n < 400 && ((lane == 0 && busy0) || (lane == 1 && busy1) || (lane == 3 && busy3))) begin
      tick(1);
      n++;
    end
    if (n >= 400) noteFail({tag, " timeout waiting for idle"});
    tick(2);
  endtask

  task automatic waitKey1(input int idx, input logic calc, input string tag);
    int n = 0;
    while (n < 200 && !((calc ? (busy1 && !rk_valid1) : rk_valid1) && rk_idx1 == 4'(idx))) begin
      tick(1);
      n++;
    end
    if (n >= 200) noteFail({tag, " timeout waiting for round"});
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " start_ready"}, 128'(start_ready1), 128'd1);
    checkOutput({tag, " rk_valid"}, 128'(rk_valid1), 128'd0);
    checkOutput({tag, " busy"}, 128'(busy1), 128'd0);
    checkOutput({tag, " done"}, 128'(done1), 128'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int d;
    start0 = 0; start1 = 0; start3 = 0; abort1 = 0; ready1 = 1; key_drv = '0;
`ifdef AES_KEY_SCHED_CACHE_EN
    cache_idx1 = 4'd0;
`endif
    tick(2);
    // Reset values while reset is held.
    checkIdleOutputs("reset");
    checkOutput("reset rk_data", rk_data1, 128'd0);
    checkOutput("reset rk_idx", 128'(rk_idx1), 128'd0);
    checkOutput("reset sbox_in", 128'(sbox_in1), 128'd0);
    checkOutput("reset lat0 start_ready", 128'(start_ready0), 128'd1);
    checkOutput("reset lat3 start_ready", 128'(start_ready3), 128'd1);
    rst_n = 1'b1;
    tick(2);

    // Vector 1: full stream, ready tied high, spacing 3.
    d = done_cnt1;
    applyStimulus(1);
    waitIdle(1, "vec1");
    checkOutput("vec1 done count", 128'(done_cnt1 - d), 128'd1);
    checkOutput("vec1 queue drained", 128'(q1.size()), 128'd0);

    // Backpressure at round key 3.
    space_on = 1'b0;
    applyStimulus(1);
    waitKey1(3, 1'b0, "bp");
    ready1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("bp rk_valid", 128'(rk_valid1), 128'd1);
      checkOutput("bp rk_idx", 128'(rk_idx1), 128'd3);
      checkOutput("bp rk_data", rk_data1, RK[3]);
    end
    ready1 = 1'b1;
    waitIdle(1, "bp");
    checkOutput("bp queue drained", 128'(q1.size()), 128'd0);
    space_on = 1'b1;

    // Same key through S-box latencies 0 and 3.
    d = done_cnt0 + done_cnt3;
    applyStimulus(0);
    applyStimulus(3);
    waitIdle(0, "lat0");
    waitIdle(3, "lat3");
    checkOutput("lat0/3 done count", 128'(done_cnt0 + done_cnt3 - d), 128'd2);
    checkOutput("lat0 queue drained", 128'(q0.size()), 128'd0);
    checkOutput("lat3 queue drained", 128'(q3.size()), 128'd0);

    // Start while busy with another key must be ignored.
    applyStimulus(1);
    waitKey1(4, 1'b0, "busy start");
    key_drv = KEY2;
    start1  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("busy start_ready", 128'(start_ready1), 128'd0);
      tick(1);
    end
    start1 = 1'b0;
    waitIdle(1, "busy start");
    checkOutput("busy queue drained", 128'(q1.size()), 128'd0);

    // Abort during the calculation after round key 6.
    applyStimulus(1);
    waitKey1(6, 1'b1, "abort");
    abort1 = 1'b1;
    tick(1);
    abort1 = 1'b0;
    checkIdleOutputs("abort");
    q1.delete();
    d = done_cnt1;
    tick(3);
    checkOutput("abort no done", 128'(done_cnt1 - d), 128'd0);
    applyStimulus(1);
    waitIdle(1, "after abort");
    checkOutput("after abort done", 128'(done_cnt1 - d), 128'd1);
    checkOutput("after abort drained", 128'(q1.size()), 128'd0);

`ifdef AES_KEY_SCHED_CACHE_EN
    cache_idx1 = 4'd10;
    tick(1);
    checkOutput("cache rk10", cache_data1, RK[10]);
    checkOutput("cache valid", 128'(cache_valid1), 128'd1);
    cache_idx1 = 4'd2;
    tick(1);
    checkOutput("cache rk2", cache_data1, RK[2]);
    cache_idx1 = 4'd15;
    tick(1);
    checkOutput("cache out of range", cache_data1, 128'd0);
`endif

    // Reset asserted mid-stream.
    applyStimulus(1);
`ifdef AES_KEY_SCHED_CACHE_EN
    checkOutput("cache cleared by start", 128'(cache_valid1), 128'd0);
`endif
    waitKey1(5, 1'b0, "midreset");
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("midreset");
    checkOutput("midreset rk_data", rk_data1, 128'd0);
    checkOutput("midreset rk_idx", 128'(rk_idx1), 128'd0);
`ifdef AES_KEY_SCHED_CACHE_EN
    checkOutput("midreset cache_valid", 128'(cache_valid1), 128'd0);
    checkOutput("midreset cache_data", cache_data1, 128'd0);
`endif
    q1.delete();
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checkOutput("final lat1 queue", 128'(q1.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Iterative AES-128 key-schedule sequencer.
- Accepts a 128-bit cipher key and streams round keys 0..NUM_ROUNDS, one per valid/ready handshake, to the round datapath.
- Time-shares one external 4-byte S-box for SubWord, with configurable S-box latency.
- Sits between key load logic and the encryption round pipeline.

Parameters:
- NUM_ROUNDS, 10, last round-key index emitted; legal range 1..10.
- SBOX_LAT, 1, cycles from sbox_in to valid sbox_out; legal range 0..3.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a new expansion; accepted when start && start_ready.
- key_in  in  128  cipher key, sampled on start acceptance; key_in[127:96]=w0, [31:0]=w3, MSB byte first (FIPS-197 order).
- start_ready  out  1  high only in IDLE.
- abort  in  1  synchronous cancel of the current expansion.
- sbox_in  out  32  RotWord(w3) of the current round key, held stable during CALC.
- sbox_out  in  32  SubWord result, valid SBOX_LAT cycles after sbox_in is stable.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts; transfer happens on rk_valid && rk_ready.
- rk_data  out  128  round key, same word order as key_in.
- rk_idx  out  4  round index of rk_data, 0..NUM_ROUNDS.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last round key transfers.

Behaviour:
- Reset: all outputs 0 except start_ready=1. State=IDLE, key regs=0, rcon=8'h01, round=0, wait counter=0.
- States: IDLE, EMIT, CALC.
- IDLE:
  - On start: latch key_in into w0..w3, round=0, rcon=01, go to EMIT.
  - rk_valid rises on the next cycle, so latency from start to round key 0 is 1 cycle.
- EMIT:
  - rk_valid=1; rk_data and rk_idx held stable until the handshake completes.
  - Handshake with round<NUM_ROUNDS: go to CALC, wait counter=SBOX_LAT.
  - Handshake with round==NUM_ROUNDS: pulse done next cycle, return to IDLE.
- CALC:
  - sbox_in = {w3[23:0], w3[31:24]}.
  - While wait counter>0, decrement it.
  - When the counter is 0, sample sbox_out and compute the next round key:
    - t = sbox_out ^ {rcon, 24'h0}
    - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'
  - Register w0'..w3', round+=1, then:
    - rcon = rcon[7] ? (rcon<<1)^8'h1b : rcon<<1, giving 01,02,04,08,10,20,40,80,1b,36.
    - go to EMIT.
  - CALC lasts SBOX_LAT+1 cycles.
- Throughput with rk_ready tied high: one key per SBOX_LAT+2 cycles.
- rk_valid never drops without a handshake, except on abort or reset.
- start while busy: ignored; start_ready=0; no state change.
- abort (any non-IDLE state): next cycle state=IDLE, rk_valid=0, busy=0, no done pulse. abort in IDLE has no effect.
- abort and start in the same cycle while in IDLE: start wins.
- Handshake and abort in the same cycle: abort wins; the transfer still counts for the consumer, but no further keys are emitted.
- Reset asserted mid-expansion: immediate return to reset values; rk_valid drops asynchronously.
- sbox_out is ignored outside the sampling cycle.

Optional Feature:
- Macro: AES_KEY_SCHED_CACHE_EN.
- Defined:
  - Adds an (NUM_ROUNDS+1)x128 round-key store, written on every EMIT handshake at address rk_idx.
  - Adds ports cache_rd_idx (in, 4) and cache_rd_data (out, 128), with cache_rd_data registered 1 cycle after cache_rd_idx.
  - Adds port cache_valid (out, 1): set with done, cleared on start acceptance, abort and reset.
  - An out-of-range index reads 0.
- Not defined: none of these ports or storage exist; behaviour is otherwise identical.

Test Plan:
- Vector 1:
  - Stimulus: SBOX_LAT=1, rk_ready=1, start with key 2b7e1516_28aed2a6_abf71588_09cf4f3c, ideal S-box model.
  - Response: rk0 equals the key, one cycle after start.
  - Response: rk1 = a0fafe17_88542cb1_23a33939_2a6c7605.
  - Response: rk10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6 with rk_idx=10.
  - Response: done pulses once; keys are spaced exactly 3 cycles apart.
- Backpressure: hold rk_ready=0 for 5 cycles at rk_idx=3 -> rk_valid stays 1; rk_data and rk_idx stay stable; no advance until ready.
- SBOX_LAT=0 and SBOX_LAT=3 with the same key -> identical key stream; spacing is 2 and 5 cycles respectively.
- Start while busy at rk_idx=4 with a different key -> ignored; the stream finishes with the original key's rk10; start_ready=0 throughout.
- abort during CALC of round 6 -> next cycle IDLE, rk_valid=0, no done; a new start then yields correct rk0..rk10.
- With AES_KEY_SCHED_CACHE_EN:
  - After completion, cache_rd_idx=10 gives d014f9a8… one cycle later, with cache_valid=1.
  - A new start clears cache_valid.
  - Asserting rst_n low mid-stream returns all outputs to reset values.
